// File: rtl/rede_float_pkg.sv
// Shared rede_float constants: core-array geometry and the no-output port code.
package rede_float_pkg;

    localparam int unsigned N_CORES_DEF = 22;
    localparam int unsigned DATA_W_DEF  = 28;
    localparam int unsigned EN_W_DEF    = 4;
    localparam int unsigned DEPTH_DEF   = 16;

    localparam int unsigned PORT_NONE   = 0;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/coll_fifo.sv
// Output FIFO for the collector; push on a full FIFO is accepted when it is popped in that cycle.
module coll_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/out_collector.sv
// Collects events from non-stallable cores into per-core slots and drains them round-robin
// into a single output FIFO, counting events lost to a still-occupied slot.
module out_collector
    import rede_float_pkg::*;
#(
    parameter  int unsigned N_CORES = N_CORES_DEF,
    parameter  int unsigned DATA_W  = DATA_W_DEF,
    parameter  int unsigned EN_W    = EN_W_DEF,
    parameter  int unsigned DEPTH   = DEPTH_DEF,
    localparam int unsigned IDX_W   = idx_width(N_CORES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CORES*DATA_W-1:0] io_out,
    input  logic [N_CORES*EN_W-1:0]   out_en,
    output logic signed [DATA_W-1:0]  m_data,
    output logic [IDX_W-1:0]          m_core,
    output logic [EN_W-1:0]           m_port,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      overflow,
    output logic [15:0]               drop_cnt
);

    localparam int unsigned ENTRY_W = DATA_W + IDX_W + EN_W;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

    logic [N_CORES-1:0] slot_full;
    logic [N_CORES-1:0] slot_full_d;
    logic [DATA_W-1:0]  slot_data [N_CORES];
    logic [EN_W-1:0]    slot_port [N_CORES];
    logic [N_CORES-1:0] ev;
    logic [N_CORES-1:0] drain;
    logic [N_CORES-1:0] drop;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [15:0]        drop_cnt_d;
    logic [16:0]        drop_sum;
    int unsigned        n_drop;

    // Search starts at rr_ptr, which always holds the index after the last granted core.
    always_comb begin
        int j;
        grant_valid = 1'b0;
        grant_idx   = '0;
        j           = 0;
        for (int k = 0; k < int'(N_CORES); k++) begin
            j = int'(rr_ptr) + k;
            if (j >= int'(N_CORES)) begin
                j = j - int'(N_CORES);
            end
            if (!grant_valid && slot_full[j]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(j);
            end
        end
    end

    assign pop        = m_ready && !fifo_empty;
    assign m_valid    = (fifo_count != '0);
    assign push       = grant_valid && (!fifo_full || pop);
    assign push_entry = {slot_data[grant_idx], grant_idx, slot_port[grant_idx]};
    assign {m_data, m_core, m_port} = head_entry;

    always_comb begin
        n_drop = 0;
        for (int i = 0; i < int'(N_CORES); i++) begin
            ev[i]    = (out_en[i*EN_W +: EN_W] != EN_W'(PORT_NONE));
            drain[i] = push && (grant_idx == IDX_W'(i));
            drop[i]  = ev[i] && slot_full[i] && !drain[i];
            if (drop[i]) begin
                n_drop = n_drop + 1;
            end
        end
        slot_full_d = (slot_full & ~drain) | ev;
        drop_sum    = {1'b0, drop_cnt} + 17'(n_drop);
        drop_cnt_d  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_full <= '0;
            rr_ptr    <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            for (int i = 0; i < int'(N_CORES); i++) begin
                if (ev[i] && (!slot_full[i] || drain[i])) begin
                    slot_data[i] <= io_out[i*DATA_W +: DATA_W];
                    slot_port[i] <= out_en[i*EN_W +: EN_W];
                end
            end
            slot_full <= slot_full_d;
            if (push) begin
                rr_ptr <= (grant_idx == IDX_W'(N_CORES - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (|drop) begin
                overflow <= 1'b1;
            end
            drop_cnt <= drop_cnt_d;
        end
    end

    coll_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_out_collector.sv
// Directed bench for out_collector: inputs change and outputs are sampled on the falling edge.
module tb_out_collector;

    localparam int unsigned N_CORES = 22;
    localparam int unsigned DATA_W  = 28;
    localparam int unsigned EN_W    = 4;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned IDX_W   = 5;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [N_CORES*DATA_W-1:0] io_out;
    logic [N_CORES*EN_W-1:0]   out_en;
    logic signed [DATA_W-1:0]  m_data;
    logic [IDX_W-1:0]          m_core;
    logic [EN_W-1:0]           m_port;
    logic                      m_valid;
    logic                      m_ready;
    logic                      overflow;
    logic [15:0]               drop_cnt;

    int checks   = 0;
    int failures = 0;
    int got;
    int k;

    always #5 clk = ~clk;

    out_collector #(
        .N_CORES (N_CORES),
        .DATA_W  (DATA_W),
        .EN_W    (EN_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .io_out   (io_out),
        .out_en   (out_en),
        .m_data   (m_data),
        .m_core   (m_core),
        .m_port   (m_port),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fire(input int c, input int d, input int p);
        out_en[c*EN_W +: EN_W]     = EN_W'(p);
        io_out[c*DATA_W +: DATA_W] = DATA_W'(d);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic chk_head(input string tag, input int c, input int d, input int p);
        chk({tag, "_valid"}, 32'(m_valid), 32'd1);
        chk({tag, "_core"}, 32'(m_core), 32'(c));
        chk({tag, "_data"}, int'(m_data), d);
        chk({tag, "_port"}, 32'(m_port), 32'(p));
    endtask

    initial begin
        rst     = 1'b0;
        m_ready = 1'b0;
        out_en  = '0;
        io_out  = '0;
        tick();
        tick();
        rst = 1'b1;

        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", int'(m_data), 0);
        chk("rst_core", 32'(m_core), 32'd0);
        chk("rst_port", 32'(m_port), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);

        // Single event, two-cycle latency.
        m_ready = 1'b1;
        fire(3, -5, 1);
        tick();
        out_en = '0;
        chk("single_lat1", 32'(m_valid), 32'd0);
        tick();
        chk_head("single", 3, -5, 1);
        tick();
        chk("single_gone", 32'(m_valid), 32'd0);
        chk("single_zero", int'(m_data), 0);

        // Simultaneous events, pointer at 0.
        do_reset();
        fire(0, 10, 2);
        fire(7, 70, 3);
        fire(21, 210, 4);
        tick();
        out_en = '0;
        tick();
        chk_head("sim0", 0, 10, 2);
        tick();
        chk_head("sim1", 7, 70, 3);
        tick();
        chk_head("sim2", 21, 210, 4);
        tick();
        chk("sim_end", 32'(m_valid), 32'd0);
        chk("sim_ovf", 32'(overflow), 32'd0);

        // Backpressure: 20 events, FIFO holds 16, rest in slots.
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i >= 2) begin
                chk($sformatf("bp_head_core%0d", i), 32'(m_core), 32'd0);
                chk($sformatf("bp_head_data%0d", i), int'(m_data), 1000);
            end
            out_en = '0;
            fire(i, 1000 + i, (i % 15) + 1);
            tick();
        end
        out_en = '0;
        chk_head("bp_hold", 0, 1000, 1);
        chk("bp_ovf", 32'(overflow), 32'd0);
        chk("bp_drop", 32'(drop_cnt), 32'd0);

        // Drop: core 5 fires three times while the FIFO is full.
        for (int i = 0; i < 3; i++) begin
            fire(5, 500 + i, 7);
            tick();
        end
        out_en = '0;
        chk("drop_ovf", 32'(overflow), 32'd1);
        chk("drop_cnt", 32'(drop_cnt), 32'd2);
        chk_head("drop_head", 0, 1000, 1);

        m_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 80 && got < 21; cyc++) begin
            if (m_valid) begin
                if (got < 20) begin
                    chk($sformatf("bp_out_core%0d", got), 32'(m_core), 32'(got));
                    chk($sformatf("bp_out_data%0d", got), int'(m_data), 1000 + got);
                    chk($sformatf("bp_out_port%0d", got), 32'(m_port), 32'((got % 15) + 1));
                end else begin
                    chk_head("drop_kept", 5, 500, 7);
                end
                got++;
            end
            tick();
        end
        chk("bp_out_count", 32'(got), 32'd21);
        chk("bp_out_empty", 32'(m_valid), 32'd0);
        chk("bp_drop_kept", 32'(drop_cnt), 32'd2);

        // Mid-run reset with 10 entries queued.
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            out_en = '0;
            fire(i, i, 1);
            tick();
        end
        out_en = '0;
        tick();
        tick();
        chk("mrst_pre_valid", 32'(m_valid), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mrst_valid", 32'(m_valid), 32'd0);
        chk("mrst_drop", 32'(drop_cnt), 32'd0);
        chk("mrst_ovf", 32'(overflow), 32'd0);
        chk("mrst_data", int'(m_data), 0);
        tick();
        tick();
        chk("mrst_valid2", 32'(m_valid), 32'd0);

        // Wrap and full push/pop: 48 back-to-back events, m_ready toggling.
        do_reset();
        k   = 0;
        got = 0;
        for (int cyc = 0; cyc < 400 && got < 48; cyc++) begin
            m_ready = cyc[0];
            out_en  = '0;
            if (k < 48) begin
                fire(k % 22, k * 37 - 500, (k % 15) + 1);
                k++;
            end
            if (m_valid && m_ready) begin
                chk($sformatf("wrap_core%0d", got), 32'(m_core), 32'(got % 22));
                chk($sformatf("wrap_data%0d", got), int'(m_data), got * 37 - 500);
                chk($sformatf("wrap_port%0d", got), 32'(m_port), 32'((got % 15) + 1));
                got++;
            end
            tick();
        end
        out_en = '0;
        chk("wrap_count", 32'(got), 32'd48);
        chk("wrap_drop", 32'(drop_cnt), 32'd0);
        chk("wrap_ovf", 32'(overflow), 32'd0);
        tick();
        chk("wrap_empty", 32'(m_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
